// File: rtl/data_mem_target_if.sv
// CPU data-memory bus plus the console byte stream and LED outputs of data_mem_target.
// The CPU side (master) issues one-cycle we/re strobes; the target answers on rdata one cycle later.
interface data_mem_target_if;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] raddr;
    logic        re;
    logic [15:0] rdata;
    logic [15:0] leds;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;

    modport master (
        output waddr, wdata, we, raddr, re, console_ready,
        input  rdata, leds, console_data, console_valid
    );

    modport slave (
        input  waddr, wdata, we, raddr, re, console_ready,
        output rdata, leds, console_data, console_valid
    );
endinterface

// File: rtl/data_mem_target.sv
// Data-memory responder: word RAM at 0..RAM_WORDS-1 plus an MMIO page at 0xFF00-0xFF03
// (LEDS, console FIFO/status, cycle counter low word, latched high-word shadow).
module data_mem_target #(
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    data_mem_target_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam logic [15:0] A_LEDS    = 16'hFF00;
    localparam logic [15:0] A_CONSOLE = 16'hFF01;
    localparam logic [15:0] A_CNT_LO  = 16'hFF02;
    localparam logic [15:0] A_CNT_HI  = 16'hFF03;
    localparam logic [2:0]  FULL_CNT  = 3'(FIFO_DEPTH);

    logic [15:0] r_ram [RAM_WORDS];
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [1:0]  r_wp;
    logic [1:0]  r_rp;
    logic [2:0]  r_count;
    logic        r_ovf;
    logic [31:0] r_cnt;
    logic [15:0] r_shadow;
    logic [15:0] r_leds;
    logic [15:0] r_rdata;

    logic        w_rd_ram;
    logic        w_wr_ram;
    logic        w_full;
    logic        w_empty;
    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_push_ok;
    logic        w_push_drop;
    logic        w_stat_rd;
    logic [15:0] w_status;
    logic [15:0] w_rd_val;

    assign w_rd_ram    = {1'b0, bus.raddr} < 17'(RAM_WORDS);
    assign w_wr_ram    = {1'b0, bus.waddr} < 17'(RAM_WORDS);
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == 3'd0);
    assign w_valid     = !w_empty;
    // Console stream: a byte transfers on every cycle where console_valid && console_ready.
    assign w_pop       = w_valid && bus.console_ready;
    assign w_push      = bus.we && (bus.waddr == A_CONSOLE);
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_push_drop = w_push && w_full && !w_pop;
    assign w_stat_rd   = bus.re && (bus.raddr == A_CONSOLE);
    assign w_status    = {10'd0, r_ovf, r_count, w_empty, w_full};

    // Read mux sees pre-edge state, which gives read-before-write for every target.
    always_comb begin
        w_rd_val = 16'h0000;
        if (w_rd_ram) begin
            w_rd_val = r_ram[bus.raddr[AW-1:0]];
        end else begin
            case (bus.raddr)
                A_LEDS:    w_rd_val = r_leds;
                A_CONSOLE: w_rd_val = w_status;
                A_CNT_LO:  w_rd_val = r_cnt[15:0];
                A_CNT_HI:  w_rd_val = r_shadow;
                default:   w_rd_val = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.we && w_wr_ram) begin
            r_ram[bus.waddr[AW-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= 16'h0000;
            r_leds   <= 16'h0000;
            r_cnt    <= 32'd0;
            r_shadow <= 16'h0000;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (bus.re) begin
                r_rdata <= w_rd_val;
            end
            if (bus.re && (bus.raddr == A_CNT_LO)) begin
                r_shadow <= r_cnt[31:16];
            end
            if (bus.we && (bus.waddr == A_LEDS)) begin
                r_leds <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wp] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= 2'd0;
            r_rp    <= 2'd0;
            r_count <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rp <= r_rp + 2'd1;
            end
            if (w_push_ok) begin
                r_wp <= r_wp + 2'd1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 3'd1;
            end
            // A drop in the same cycle as a status read is kept, so no overflow is lost.
            if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end
            if (w_push_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.rdata         = r_rdata;
    assign bus.leds          = r_leds;
    assign bus.console_valid = w_valid;
    assign bus.console_data  = w_valid ? r_fifo[r_rp] : 8'h00;
endmodule

// File: tb/tb_data_mem_target.sv
// Self-checking bench for data_mem_target: a queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_data_mem_target;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_mem_target_if bus();

    data_mem_target #(.RAM_WORDS(4096), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_ram [4096];
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic [31:0] m_cnt;
    logic [15:0] m_shadow;
    logic [15:0] m_leds;
    logic [15:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_status();
        int sz;
        sz = m_q.size();
        return {10'd0, m_ovf, 3'(sz), (sz == 0), (sz == 4)};
    endfunction

    task automatic model_step();
        int   sz;
        logic pop;
        if (rst) begin
            m_rdata  = 16'h0;
            m_leds   = 16'h0;
            m_q.delete();
            m_ovf    = 1'b0;
            m_cnt    = 32'd0;
            m_shadow = 16'h0;
            return;
        end
        sz = m_q.size();
        if (bus.re) begin
            if (bus.raddr < 16'd4096)         m_rdata = m_ram[bus.raddr[11:0]];
            else if (bus.raddr == 16'hFF00)   m_rdata = m_leds;
            else if (bus.raddr == 16'hFF01)   m_rdata = model_status();
            else if (bus.raddr == 16'hFF02)   m_rdata = m_cnt[15:0];
            else if (bus.raddr == 16'hFF03)   m_rdata = m_shadow;
            else                              m_rdata = 16'h0;
            if (bus.raddr == 16'hFF02) m_shadow = m_cnt[31:16];
            if (bus.raddr == 16'hFF01) m_ovf = 1'b0;
        end
        pop = (sz != 0) && bus.console_ready;
        if (pop) void'(m_q.pop_front());
        if (bus.we && bus.waddr == 16'hFF01) begin
            if (sz < 4 || pop) m_q.push_back(bus.wdata[7:0]);
            else               m_ovf = 1'b1;
        end
        if (bus.we && bus.waddr < 16'd4096) m_ram[bus.waddr[11:0]] = bus.wdata;
        if (bus.we && bus.waddr == 16'hFF00) m_leds = bus.wdata;
        m_cnt = m_cnt + 32'd1;
    endtask

    // Model advances on each edge; DUT outputs are compared 1 time unit later.
    always @(posedge clk) begin
        logic [7:0] exp_data;
        model_step();
        #1;
        exp_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
        chk("rdata", 32'(bus.rdata), 32'(m_rdata));
        chk("leds", 32'(bus.leds), 32'(m_leds));
        chk("console_valid", 32'(bus.console_valid), 32'(m_q.size() != 0));
        chk("console_data", 32'(bus.console_data), 32'(exp_data));
    end

    task automatic cyc(input logic w, input logic [15:0] wa, input logic [15:0] wd,
                       input logic r, input logic [15:0] ra, input logic rdy);
        bus.we            = w;
        bus.waddr         = wa;
        bus.wdata         = wd;
        bus.re            = r;
        bus.raddr         = ra;
        bus.console_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, a, d, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, a, 1'b0);
    endtask

    function automatic logic [15:0] pick_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 3)      return 16'($urandom_range(0, 4095));
        else if (sel <= 7) return 16'h1000 + 16'hEF00 + 16'($urandom_range(0, 3));
        else if (sel == 8) return 16'($urandom_range(16'h1000, 16'hFEFF));
        else               return 16'($urandom_range(16'hFF04, 16'hFFFF));
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        chk("reset_rdata", 32'(bus.rdata), 32'h0);
        chk("reset_leds", 32'(bus.leds), 32'h0);
        chk("reset_valid", 32'(bus.console_valid), 32'h0);

        for (int i = 0; i < 4096; i++) wr(16'(i), 16'(i * 3 + 7));
        wr(16'h0010, 16'h0001);

        // Basic write then read, data held with re low
        wr(16'h0005, 16'h1234);
        rd(16'h0005);
        chk("ram_read", 32'(bus.rdata), 32'h1234);
        idle();
        chk("ram_hold", 32'(bus.rdata), 32'h1234);

        // Same-cycle read and write to one address
        cyc(1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0010, 1'b0);
        chk("rbw_old", 32'(bus.rdata), 32'h0001);
        rd(16'h0010);
        chk("rbw_new", 32'(bus.rdata), 32'hBEEF);

        // Overflowing push sequence
        for (int i = 0; i < 5; i++) wr(16'hFF01, 16'h0041 + 16'(i));
        rd(16'hFF01);
        chk("status_ovf", 32'(bus.rdata), 32'h0031);
        rd(16'hFF01);
        chk("status_ovf_clr", 32'(bus.rdata), 32'h0011);
        for (int i = 0; i < 4; i++) begin
            chk("drain_byte", 32'(bus.console_data), 32'h41 + 32'(i));
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        end
        chk("drain_empty", 32'(bus.console_valid), 32'h0);
        rd(16'hFF01);
        chk("status_empty", 32'(bus.rdata), 32'h0002);

        // Push into a full FIFO while it pops
        for (int i = 0; i < 4; i++) wr(16'hFF01, 16'h0011 + 16'(i));
        chk("full_head", 32'(bus.console_data), 32'h11);
        cyc(1'b1, 16'hFF01, 16'h005A, 1'b0, 16'h0, 1'b1);
        rd(16'hFF01);
        chk("status_full_noovf", 32'(bus.rdata), 32'h0011);
        for (int i = 0; i < 4; i++) begin
            chk("pushpop_order", 32'(bus.console_data), (i == 3) ? 32'h5A : 32'h12 + 32'(i));
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        end

        // Reset mid-operation
        wr(16'hFF00, 16'hA5A5);
        rd(16'hFF00);
        chk("leds_read", 32'(bus.rdata), 32'hA5A5);
        chk("leds_out", 32'(bus.leds), 32'hA5A5);
        wr(16'hFF01, 16'h0061);
        wr(16'hFF01, 16'h0062);
        chk("pre_reset_valid", 32'(bus.console_valid), 32'h1);
        rst = 1'b1;
        rd(16'h0005);
        rst = 1'b0;
        chk("mid_reset_leds", 32'(bus.leds), 32'h0);
        chk("mid_reset_valid", 32'(bus.console_valid), 32'h0);
        chk("mid_reset_rdata", 32'(bus.rdata), 32'h0);

        // Counter: cycle 0 after reset, then low-word wrap and shadow behaviour
        rd(16'hFF02);
        chk("cnt_first", 32'(bus.rdata), 32'h0000);
        repeat (16'hFFFE) idle();
        rd(16'hFF02);
        chk("cnt_lo_ffff", 32'(bus.rdata), 32'hFFFF);
        rd(16'hFF03);
        chk("cnt_hi_shadow", 32'(bus.rdata), 32'h0000);
        rd(16'hFF02);
        chk("cnt_lo_wrap", 32'(bus.rdata), 32'h0001);
        rd(16'hFF03);
        chk("cnt_hi_latched", 32'(bus.rdata), 32'h0001);
        rd(16'h0005);
        chk("ram_survives_reset", 32'(bus.rdata), 32'h1234);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            cyc(1'($urandom_range(0, 1)), pick_addr(), 16'($urandom),
                1'($urandom_range(0, 1)), pick_addr(), ($urandom_range(0, 3) == 0));
        end
        rst = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
